// File: rtl/sdram_burst_arbiter_if.sv
// Controller-side bus between the burst arbiter (master) and the SDRAM controller (slave).
// One request strobe per burst; per-word strobes come back from the controller.
interface sdram_burst_arbiter_if;
    logic        rw;
    logic        rw_en;
    logic [14:0] f_addr;
    logic [15:0] f2s_data;
    logic        f2s_data_valid;
    logic [15:0] s2f_data;
    logic        s2f_data_valid;
    logic        ready;

    modport master (
        output rw, rw_en, f_addr, f2s_data,
        input  f2s_data_valid, s2f_data, s2f_data_valid, ready
    );

    modport slave (
        input  rw, rw_en, f_addr, f2s_data,
        output f2s_data_valid, s2f_data, s2f_data_valid, ready
    );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Arbitrates full-page SDRAM bursts between a camera write FIFO and a display read FIFO.
// Grant 1 cycle after eligibility with ready=1; data path is zero-latency; controller paces words via strobes.
module sdram_burst_arbiter #(
    parameter int BURST_LEN     = 512,
    parameter int FRAME_BURSTS  = 600,
    parameter int WR_HIGH_WATER = 1536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] wr_level,
    input  logic [15:0] wr_fifo_data,
    output logic        wr_fifo_rd_en,
    input  logic [10:0] rd_free,
    output logic        rd_fifo_wr_en,
    output logic [15:0] rd_fifo_data,
    input  logic        wr_frame_start,
    input  logic        rd_frame_start,
    sdram_burst_arbiter_if.master ctrl,
    output logic        grant_wr,
    output logic        grant_rd,
    output logic        burst_err
);
    localparam logic [10:0] BURST_LVL = 11'(BURST_LEN);
    localparam logic [10:0] HIGH_LVL  = 11'(WR_HIGH_WATER);
    localparam logic [9:0]  BEATS     = 10'(BURST_LEN);
    localparam logic [14:0] PTR_LAST  = 15'(FRAME_BURSTS - 1);
    localparam logic [11:0] WD_LIMIT  = 12'hFFF;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_BUSY, S_XFER, S_WAIT_READY} state_t;
    state_t state, state_nxt;

    logic        rw_q;
    logic [14:0] addr_q;
    logic [14:0] wr_ptr, rd_ptr, wr_eff, rd_eff, wr_inc, rd_inc;
    logic        wr_pend, rd_pend, last_wr;
    logic [9:0]  beat_cnt;
    logic [11:0] wd_cnt;
    logic        we, re, high, pick_wr, arb_go, beat, beat_done, busy, wd_expire, upd;

    assign we     = wr_level >= BURST_LVL;
    assign re     = rd_free >= BURST_LVL;
    assign high   = we && (wr_level >= HIGH_LVL);
    assign arb_go = (state == S_IDLE) && ctrl.ready && (we || re);

    always_comb begin
        pick_wr = 1'b0;
        if (high)          pick_wr = 1'b1;
        else if (we && re) pick_wr = !last_wr;
        else               pick_wr = we;
    end

    // A pending frame restart makes the pointer read as 0 before it is physically cleared.
    assign wr_eff = (wr_pend || wr_frame_start) ? '0 : wr_ptr;
    assign rd_eff = (rd_pend || rd_frame_start) ? '0 : rd_ptr;
    assign wr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 15'd1;
    assign rd_inc = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 15'd1;

    assign beat      = (grant_wr && ctrl.f2s_data_valid) || (grant_rd && ctrl.s2f_data_valid);
    assign beat_done = beat && ((beat_cnt + 10'd1) == BEATS);
    assign busy      = (state == S_WAIT_BUSY) || (state == S_XFER) || (state == S_WAIT_READY);
    assign wd_expire = busy && (wd_cnt == WD_LIMIT);
    assign upd       = (state == S_WAIT_READY) && ctrl.ready && !wd_expire;

    assign ctrl.f2s_data = wr_fifo_data;
    assign wr_fifo_rd_en = ctrl.f2s_data_valid && grant_wr;
    assign rd_fifo_data  = ctrl.s2f_data;
    assign rd_fifo_wr_en = ctrl.s2f_data_valid && grant_rd;
    assign ctrl.rw       = rw_q;
    assign ctrl.f_addr   = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (arb_go) state_nxt = S_REQ;
            S_REQ:        state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY:  if (!ctrl.ready || beat) state_nxt = S_XFER;
            S_XFER:       if (beat_done) state_nxt = S_WAIT_READY;
            S_WAIT_READY: if (ctrl.ready) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
        if (wd_expire) state_nxt = S_IDLE;
    end

    always_comb begin
        ctrl.rw_en = (state == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q      <= 1'b0;
            addr_q    <= '0;
            grant_wr  <= 1'b0;
            grant_rd  <= 1'b0;
            last_wr   <= 1'b0;
            burst_err <= 1'b0;
            beat_cnt  <= '0;
            wd_cnt    <= '0;
        end else begin
            wd_cnt <= busy ? wd_cnt + 12'd1 : '0;
            if ((state == S_WAIT_BUSY || state == S_XFER) && beat) beat_cnt <= beat_cnt + 10'd1;
            else if (state == S_IDLE)                             beat_cnt <= '0;
            if (wd_expire) begin
                burst_err <= 1'b1;
                grant_wr  <= 1'b0;
                grant_rd  <= 1'b0;
            end else if (arb_go) begin
                grant_wr <= pick_wr;
                grant_rd <= !pick_wr;
                rw_q     <= !pick_wr;
                addr_q   <= pick_wr ? wr_eff : rd_eff;
                last_wr  <= pick_wr;
            end else if (upd) begin
                grant_wr <= 1'b0;
                grant_rd <= 1'b0;
            end
        end
    end

    // A frame restart lands at the owning port's next update point, or at once if that port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            if (upd && grant_wr) begin
                wr_ptr  <= (wr_pend || wr_frame_start) ? '0 : wr_inc;
                wr_pend <= 1'b0;
            end else if (state == S_IDLE && (wr_pend || wr_frame_start)) begin
                wr_ptr  <= '0;
                wr_pend <= 1'b0;
            end else if (wr_frame_start) begin
                wr_pend <= 1'b1;
            end
            if (upd && grant_rd) begin
                rd_ptr  <= (rd_pend || rd_frame_start) ? '0 : rd_inc;
                rd_pend <= 1'b0;
            end else if (state == S_IDLE && (rd_pend || rd_frame_start)) begin
                rd_ptr  <= '0;
                rd_pend <= 1'b0;
            end else if (rd_frame_start) begin
                rd_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter; a short frame keeps pointer-wrap runs affordable.
module tb_sdram_burst_arbiter;
    localparam int FB = 39;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] wr_level = '0;
    logic [10:0] rd_free = '0;
    logic [15:0] wr_fifo_data = '0;
    logic        wr_frame_start = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        wr_fifo_rd_en, rd_fifo_wr_en, grant_wr, grant_rd, burst_err;
    logic [15:0] rd_fifo_data;
    int          n_total = 0;
    int          n_bad = 0;
    int          pops = 0;
    int          pushes = 0;

    sdram_burst_arbiter_if bus();

    sdram_burst_arbiter #(.FRAME_BURSTS(FB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_level       (wr_level),
        .wr_fifo_data   (wr_fifo_data),
        .wr_fifo_rd_en  (wr_fifo_rd_en),
        .rd_free        (rd_free),
        .rd_fifo_wr_en  (rd_fifo_wr_en),
        .rd_fifo_data   (rd_fifo_data),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .ctrl           (bus),
        .grant_wr       (grant_wr),
        .grant_rd       (grant_rd),
        .burst_err      (burst_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_fifo_rd_en) pops++;
        if (rd_fifo_wr_en) pushes++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int  n = 0;
        bit  ok = 1'b0;
        while (!ok && n < 40) begin
            step();
            n++;
            if (bus.rw_en === 1'b1) ok = 1'b1;
        end
        check_eq("req_seen", 32'(ok), 1);
    endtask

    // Called in the REQ cycle; mode 1 pulses rd_frame_start at beat 200, mode 2 pulses wr_frame_start with the final ready.
    task automatic do_burst(input bit is_wr, input int beats, input int mode);
        bus.ready = 1'b0;
        step();
        check_eq("rw_en_one_cycle", 32'(bus.rw_en), 0);
        for (int i = 0; i < beats; i++) begin
            if (is_wr) bus.f2s_data_valid = 1'b1;
            else       bus.s2f_data_valid = 1'b1;
            if (mode == 1 && i == 200) rd_frame_start = 1'b1;
            step();
            rd_frame_start = 1'b0;
        end
        bus.f2s_data_valid = 1'b0;
        bus.s2f_data_valid = 1'b0;
        step();
        check_eq("grant_held", 32'({grant_wr, grant_rd}), is_wr ? 2 : 1);
        bus.ready = 1'b1;
        if (mode == 2) wr_frame_start = 1'b1;
        step();
        wr_frame_start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int p0;
        bus.ready = 1'b0;
        bus.f2s_data_valid = 1'b0;
        bus.s2f_data_valid = 1'b0;
        bus.s2f_data = '0;
        repeat (3) step();
        check_eq("rst_rw_en", 32'(bus.rw_en), 0);
        check_eq("rst_rw", 32'(bus.rw), 0);
        check_eq("rst_f_addr", 32'(bus.f_addr), 0);
        check_eq("rst_grants", 32'({grant_wr, grant_rd}), 0);
        check_eq("rst_burst_err", 32'(burst_err), 0);

        // Single write burst from reset
        rst_n = 1'b1;
        wr_level = 11'd600;
        bus.ready = 1'b1;
        wait_req();
        check_eq("w1_rw", 32'(bus.rw), 0);
        check_eq("w1_f_addr", 32'(bus.f_addr), 0);
        check_eq("w1_grants", 32'({grant_wr, grant_rd}), 2);
        wr_level = '0;
        do_burst(1'b1, 512, 0);
        check_eq("w1_pops", 32'(pops), 512);
        check_eq("w1_idle_grants", 32'({grant_wr, grant_rd}), 0);

        // Pass-through data and ungranted strobes
        wr_fifo_data = 16'hA5C3;
        bus.s2f_data = 16'h5A3C;
        bus.f2s_data_valid = 1'b1;
        bus.s2f_data_valid = 1'b1;
        #1;
        check_eq("f2s_data", 32'(bus.f2s_data), 32'h0000A5C3);
        check_eq("rd_fifo_data", 32'(rd_fifo_data), 32'h00005A3C);
        check_eq("nogrant_pop", 32'(wr_fifo_rd_en), 0);
        check_eq("nogrant_push", 32'(rd_fifo_wr_en), 0);
        step();
        bus.f2s_data_valid = 1'b0;
        bus.s2f_data_valid = 1'b0;
        check_eq("nogrant_pop_cnt", 32'(pops), 512);

        wr_level = 11'd600;
        wait_req();
        check_eq("w2_f_addr", 32'(bus.f_addr), 1);
        wr_level = '0;
        do_burst(1'b1, 512, 0);

        // Round robin: write won last, so read goes first, then write
        wr_level = 11'd600;
        rd_free = 11'd1024;
        wait_req();
        check_eq("rr_rd_rw", 32'(bus.rw), 1);
        check_eq("rr_rd_grants", 32'({grant_wr, grant_rd}), 1);
        check_eq("rr_rd_f_addr", 32'(bus.f_addr), 0);
        do_burst(1'b0, 512, 0);
        check_eq("rr_pushes", 32'(pushes), 512);
        wait_req();
        check_eq("rr_wr_rw", 32'(bus.rw), 0);
        check_eq("rr_wr_f_addr", 32'(bus.f_addr), 2);
        wr_level = '0;
        rd_free = '0;
        do_burst(1'b1, 512, 0);

        // High water overrides round robin; frame start coincides with pointer advance
        wr_level = 11'd1600;
        rd_free = 11'd1024;
        wait_req();
        check_eq("hw_grants", 32'({grant_wr, grant_rd}), 2);
        check_eq("hw_f_addr", 32'(bus.f_addr), 3);
        wr_level = '0;
        do_burst(1'b1, 512, 2);

        // Read pointer walk: wrap at FB-1, then frame start mid-burst at 37
        for (int k = 1; k <= FB - 1; k++) begin
            wait_req();
            if (k == 1 || k == FB - 1) check_eq("rd_walk_f_addr", 32'(bus.f_addr), 32'(k));
            do_burst(1'b0, 512, 0);
        end
        wait_req();
        check_eq("rd_wrap", 32'(bus.f_addr), 0);
        do_burst(1'b0, 512, 0);
        for (int k = 1; k <= 36; k++) begin
            wait_req();
            do_burst(1'b0, 512, 0);
        end
        wait_req();
        check_eq("rd_at_37", 32'(bus.f_addr), 37);
        do_burst(1'b0, 512, 1);
        wait_req();
        check_eq("rd_fs_mid", 32'(bus.f_addr), 0);
        rd_free = '0;
        do_burst(1'b0, 512, 0);

        // Watchdog: ready never drops, no strobes
        wr_level = 11'd600;
        wait_req();
        check_eq("wd_f_addr", 32'(bus.f_addr), 0);
        wr_level = '0;
        repeat (4000) step();
        check_eq("wd_not_yet", 32'(burst_err), 0);
        check_eq("wd_grant_held", 32'(grant_wr), 1);
        repeat (200) step();
        check_eq("wd_burst_err", 32'(burst_err), 1);
        check_eq("wd_grants_clear", 32'({grant_wr, grant_rd}), 0);
        wr_level = 11'd600;
        wait_req();
        check_eq("wd_ptr_unchanged", 32'(bus.f_addr), 0);
        check_eq("wd_sticky", 32'(burst_err), 1);
        wr_level = '0;
        do_burst(1'b1, 512, 0);

        // Reset in the middle of a transfer
        wr_level = 11'd600;
        wait_req();
        check_eq("rx_f_addr", 32'(bus.f_addr), 1);
        wr_level = '0;
        p0 = pops;
        bus.ready = 1'b0;
        step();
        for (int i = 0; i < 200; i++) begin
            bus.f2s_data_valid = 1'b1;
            step();
        end
        check_eq("rx_pops_200", 32'(pops - p0), 200);
        rst_n = 1'b0;
        #1;
        check_eq("rx_rw_en", 32'(bus.rw_en), 0);
        check_eq("rx_rw_addr", 32'({bus.rw, bus.f_addr}), 0);
        check_eq("rx_grants", 32'({grant_wr, grant_rd}), 0);
        check_eq("rx_pop_strobe", 32'(wr_fifo_rd_en), 0);
        check_eq("rx_burst_err", 32'(burst_err), 0);
        p0 = pops;
        repeat (3) step();
        rst_n = 1'b1;
        bus.ready = 1'b1;
        repeat (10) step();
        check_eq("rx_no_more_pops", 32'(pops - p0), 0);
        check_eq("rx_idle_grants", 32'({grant_wr, grant_rd}), 0);
        bus.f2s_data_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
